// File: rtl/keypad_digit_entry_ctrl_if.sv
// -----------------------------------------------------------------------------
// keypad_digit_entry_ctrl_if
// Bundles the keypad scanner inputs and the entry/commit outputs of
// keypad_digit_entry_ctrl.
//   master : drives tick/key_pressed/key_code, observes every output
//   slave  : the controller; consumes the scanner inputs, drives the outputs
// Parameters must match those of the controller instance it is attached to.
// -----------------------------------------------------------------------------
interface keypad_digit_entry_ctrl_if #(
   parameter int N_DIGITS   = 7,
   parameter int N_CHANNELS = 4
);
   localparam int CNT_W = $clog2(N_DIGITS + 1);
   localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

   logic                  tick;
   logic                  key_pressed;
   logic [3:0]            key_code;
   logic [4*N_DIGITS-1:0] edit_bcd;
   logic [CNT_W-1:0]      digit_count;
   logic [CH_W-1:0]       channel;
   logic [4*N_DIGITS-1:0] commit_bcd;
   logic                  commit_stb;
   logic                  toggle_a;
   logic                  toggle_b;
   logic                  next_page;
   logic                  key_accept;

   modport master (
      output tick, key_pressed, key_code,
      input  edit_bcd, digit_count, channel, commit_bcd, commit_stb,
             toggle_a, toggle_b, next_page, key_accept
   );

   modport slave (
      input  tick, key_pressed, key_code,
      output edit_bcd, digit_count, channel, commit_bcd, commit_stb,
             toggle_a, toggle_b, next_page, key_accept
   );
endinterface

// File: rtl/keypad_digit_entry_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_digit_entry_ctrl
// Debounces a 16-key keypad and turns accepted keys into BCD digit entry,
// per-channel commit registers, channel selection and two user toggles.
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : keypad_digit_entry_ctrl_if.slave
//          in  : tick (debounce time base), key_pressed, key_code[3:0]
//          out : edit_bcd, digit_count, channel, commit_bcd (combinational
//                view of the active channel's committed value), commit_stb,
//                toggle_a, toggle_b, next_page, key_accept
// An accepted key pulses key_accept; its action lands on the following edge.
// -----------------------------------------------------------------------------
module keypad_digit_entry_ctrl #(
   parameter int N_DIGITS       = 7,
   parameter int N_CHANNELS     = 4,
   parameter int DEBOUNCE_TICKS = 1000
) (
   input  logic                            clk,
   input  logic                            rst,
   keypad_digit_entry_ctrl_if.slave        bus
);
   localparam int CNT_W = $clog2(N_DIGITS + 1);
   localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
   localparam int BUF_W = 4 * N_DIGITS;

   localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_TICKS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_DIGITS);
   localparam logic [CH_W-1:0]  CH_LAST = CH_W'(N_CHANNELS - 1);

   typedef enum logic [2:0] {
      ACT_DIGIT,
      ACT_NEXT_CH,
      ACT_TOG_A,
      ACT_TOG_B,
      ACT_CONFIRM,
      ACT_ERASE,
      ACT_PAGE
   } action_e;

   // ---------------------------------------------------------------- debounce
   logic [DB_W-1:0] db_cnt;
   logic [3:0]      latched_code;
   logic [3:0]      accept_code;
   logic            held;
   logic            wait_release;   // set by reset so a key held through reset is ignored
   logic            key_accept;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt       <= '0;
         latched_code <= '0;
         accept_code  <= '0;
         held         <= 1'b0;
         wait_release <= 1'b1;
         key_accept   <= 1'b0;
      end else begin
         key_accept <= 1'b0;
         if (!bus.key_pressed) begin
            held         <= 1'b0;
            wait_release <= 1'b0;
         end
         if (!bus.key_pressed || bus.key_code != latched_code) begin
            db_cnt       <= '0;
            latched_code <= bus.key_code;
         end else if (bus.tick && db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + 1'b1;
            // Counter reaches DEBOUNCE_TICKS on this tick.
            if (db_cnt == DB_MAX - 1'b1 && !held && !wait_release) begin
               key_accept  <= 1'b1;
               held        <= 1'b1;
               accept_code <= latched_code;
            end
         end
      end
   end

   // ------------------------------------------------------------ key decode
   action_e    act;
   logic [3:0] digit;

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      act   = ACT_DIGIT;
      digit = 4'd0;
      case (accept_code)
         4'd0:  digit = 4'd1;
         4'd1:  digit = 4'd2;
         4'd2:  digit = 4'd3;
         4'd3:  act   = ACT_NEXT_CH;
         4'd4:  digit = 4'd4;
         4'd5:  digit = 4'd5;
         4'd6:  digit = 4'd6;
         4'd7:  act   = ACT_TOG_A;
         4'd8:  digit = 4'd7;
         4'd9:  digit = 4'd8;
         4'd10: digit = 4'd9;
         4'd11: act   = ACT_TOG_B;
         4'd12: act   = ACT_CONFIRM;
         4'd13: digit = 4'd0;
         4'd14: act   = ACT_ERASE;
         4'd15: act   = ACT_PAGE;
      endcase
   end

   // -------------------------------------------------------------- datapath
   logic [BUF_W-1:0] edit_q,   edit_nxt;
   logic [CNT_W-1:0] count_q,  count_nxt;
   logic [CH_W-1:0]  ch_q,     ch_nxt;
   logic             fresh_q,  fresh_nxt;
   logic             tog_a_q,  tog_a_nxt;
   logic             tog_b_q,  tog_b_nxt;
   logic             stb_nxt,  page_nxt, commit_we;
   logic             commit_stb_q, next_page_q;

   logic [BUF_W-1:0] commit_val [N_CHANNELS];
   logic [CNT_W-1:0] commit_cnt [N_CHANNELS];

   always_comb begin
      edit_nxt  = edit_q;
      count_nxt = count_q;
      ch_nxt    = ch_q;
      fresh_nxt = fresh_q;
      tog_a_nxt = tog_a_q;
      tog_b_nxt = tog_b_q;
      stb_nxt   = 1'b0;
      page_nxt  = 1'b0;
      commit_we = 1'b0;
      if (key_accept) begin
         case (act)
            ACT_DIGIT: begin
               if (fresh_q) begin
                  if (digit != 4'd0) begin
                     edit_nxt      = '0;
                     edit_nxt[3:0] = digit;
                     count_nxt     = CNT_W'(1);
                     fresh_nxt     = 1'b0;
                  end
               end else if (count_q < CNT_MAX && !(digit == 4'd0 && count_q == '0)) begin
                  edit_nxt      = edit_q << 4;
                  edit_nxt[3:0] = digit;
                  count_nxt     = count_q + 1'b1;
               end
            end
            ACT_ERASE: begin
               if (count_q != '0) begin
                  edit_nxt  = edit_q >> 4;
                  count_nxt = count_q - 1'b1;
               end else begin
                  edit_nxt  = commit_val[ch_q];
                  count_nxt = commit_cnt[ch_q];
                  fresh_nxt = 1'b1;
               end
            end
            ACT_CONFIRM: begin
               commit_we = 1'b1;
               stb_nxt   = 1'b1;
               fresh_nxt = 1'b1;
            end
            ACT_NEXT_CH: begin
               ch_nxt    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
               edit_nxt  = commit_val[ch_nxt];
               count_nxt = commit_cnt[ch_nxt];
               fresh_nxt = 1'b1;
            end
            ACT_TOG_A: tog_a_nxt = ~tog_a_q;
            ACT_TOG_B: tog_b_nxt = ~tog_b_q;
            ACT_PAGE:  page_nxt  = 1'b1;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         edit_q       <= '0;
         count_q      <= '0;
         ch_q         <= '0;
         fresh_q      <= 1'b1;
         tog_a_q      <= 1'b0;
         tog_b_q      <= 1'b0;
         commit_stb_q <= 1'b0;
         next_page_q  <= 1'b0;
      end else begin
         edit_q       <= edit_nxt;
         count_q      <= count_nxt;
         ch_q         <= ch_nxt;
         fresh_q      <= fresh_nxt;
         tog_a_q      <= tog_a_nxt;
         tog_b_q      <= tog_b_nxt;
         commit_stb_q <= stb_nxt;
         next_page_q  <= page_nxt;
      end
   end

   // NOTE: the commit registers are a small register array, not a RAM, so
   // they are cleared on reset like any other state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CHANNELS; i++) begin
            commit_val[i] <= '0;
            commit_cnt[i] <= '0;
         end
      end else if (commit_we) begin
         commit_val[ch_q] <= edit_q;
         commit_cnt[ch_q] <= count_q;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.edit_bcd    = edit_q;
   assign bus.digit_count = count_q;
   assign bus.channel     = ch_q;
   assign bus.commit_bcd  = commit_val[ch_q];
   assign bus.commit_stb  = commit_stb_q;
   assign bus.toggle_a    = tog_a_q;
   assign bus.toggle_b    = tog_b_q;
   assign bus.next_page   = next_page_q;
   assign bus.key_accept  = key_accept;

endmodule

// File: tb/tb_keypad_digit_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_digit_entry_ctrl
// Directed bench for keypad_digit_entry_ctrl with N_DIGITS=3, N_CHANNELS=2,
// DEBOUNCE_TICKS=4 and tick asserted every cycle. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_keypad_digit_entry_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Keypad positions used below.
   localparam logic [3:0] K1 = 4'd0, K2 = 4'd1, K3 = 4'd2, K4 = 4'd4, K5 = 4'd5,
                          K7 = 4'd8, K9 = 4'd10, K0 = 4'd13, KCH = 4'd3,
                          KTA = 4'd7, KTB = 4'd11, KOK = 4'd12, KER = 4'd14,
                          KPG = 4'd15;

   keypad_digit_entry_ctrl_if #(.N_DIGITS(3), .N_CHANNELS(2)) bus ();

   keypad_digit_entry_ctrl #(
      .N_DIGITS(3), .N_CHANNELS(2), .DEBOUNCE_TICKS(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Holds a key for 'hold' cycles, releases it for 3 cycles and counts the
   // pulses seen on key_accept, commit_stb and next_page over that window.
   task automatic press(input logic [3:0] code, input int hold,
                        output int acc, output int stb, output int pg);
      acc = 0; stb = 0; pg = 0;
      @(negedge clk);
      bus.key_pressed = 1'b1;
      bus.key_code    = code;
      repeat (hold) begin
         @(posedge clk); #1;
         acc += int'(bus.key_accept);
         stb += int'(bus.commit_stb);
         pg  += int'(bus.next_page);
      end
      @(negedge clk);
      bus.key_pressed = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         acc += int'(bus.key_accept);
         stb += int'(bus.commit_stb);
         pg  += int'(bus.next_page);
      end
   endtask

   task automatic tap(input logic [3:0] code);
      int a, s, p;
      press(code, 8, a, s, p);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.key_pressed = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (bus.edit_bcd !== 12'h000) begin n_bad++; $display("FAIL reset_edit: got %h want 000", bus.edit_bcd); end
      n_cmp++; if (bus.digit_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.digit_count); end
      n_cmp++; if (bus.channel !== 1'b0) begin n_bad++; $display("FAIL reset_channel: got %0d want 0", bus.channel); end
      n_cmp++; if (bus.commit_bcd !== 12'h000) begin n_bad++; $display("FAIL reset_commit: got %h want 000", bus.commit_bcd); end
      n_cmp++; if ({bus.toggle_a, bus.toggle_b, bus.commit_stb, bus.next_page, bus.key_accept} !== 5'b0)
         begin n_bad++; $display("FAIL reset_flags: got %b want 00000",
            {bus.toggle_a, bus.toggle_b, bus.commit_stb, bus.next_page, bus.key_accept}); end
   endtask

   task automatic test_debounce();
      int a, s, p;
      press(K1, 3, a, s, p);
      n_cmp++; if (a !== 0) begin n_bad++; $display("FAIL debounce_short: got %0d accepts want 0", a); end
      n_cmp++; if (bus.digit_count !== 2'd0) begin n_bad++; $display("FAIL debounce_short_count: got %0d want 0", bus.digit_count); end
      press(K1, 10, a, s, p);
      n_cmp++; if (a !== 1) begin n_bad++; $display("FAIL debounce_long: got %0d accepts want 1", a); end
      n_cmp++; if (bus.edit_bcd !== 12'h001) begin n_bad++; $display("FAIL debounce_edit: got %h want 001", bus.edit_bcd); end
      n_cmp++; if (bus.digit_count !== 2'd1) begin n_bad++; $display("FAIL debounce_count: got %0d want 1", bus.digit_count); end
   endtask

   task automatic test_entry_overflow();
      apply_reset();
      tap(K1); tap(K2); tap(K3); tap(K4);
      n_cmp++; if (bus.edit_bcd !== 12'h123) begin n_bad++; $display("FAIL full_edit: got %h want 123", bus.edit_bcd); end
      n_cmp++; if (bus.digit_count !== 2'd3) begin n_bad++; $display("FAIL full_count: got %0d want 3", bus.digit_count); end
      tap(KOK);
      n_cmp++; if (bus.commit_bcd !== 12'h123) begin n_bad++; $display("FAIL full_commit: got %h want 123", bus.commit_bcd); end
      tap(K0);
      n_cmp++; if (bus.edit_bcd !== 12'h123 || bus.digit_count !== 2'd3)
         begin n_bad++; $display("FAIL lead_zero: got %h/%0d want 123/3", bus.edit_bcd, bus.digit_count); end
      tap(K9); tap(K0);
      n_cmp++; if (bus.edit_bcd !== 12'h090 || bus.digit_count !== 2'd2)
         begin n_bad++; $display("FAIL fresh_then_zero: got %h/%0d want 090/2", bus.edit_bcd, bus.digit_count); end
   endtask

   task automatic test_commit_restore();
      int a, s, p;
      apply_reset();
      tap(K1); tap(K2);
      press(KOK, 8, a, s, p);
      n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL commit_stb: got %0d pulses want 1", s); end
      n_cmp++; if (bus.commit_bcd !== 12'h012) begin n_bad++; $display("FAIL commit_val: got %h want 012", bus.commit_bcd); end
      tap(KER);
      n_cmp++; if (bus.edit_bcd !== 12'h001 || bus.digit_count !== 2'd1)
         begin n_bad++; $display("FAIL erase_one: got %h/%0d want 001/1", bus.edit_bcd, bus.digit_count); end
      tap(KER); tap(KER);
      n_cmp++; if (bus.edit_bcd !== 12'h012 || bus.digit_count !== 2'd2)
         begin n_bad++; $display("FAIL restore: got %h/%0d want 012/2", bus.edit_bcd, bus.digit_count); end
      // Fresh is set after restore, so a digit replaces the buffer.
      tap(K4);
      n_cmp++; if (bus.edit_bcd !== 12'h004 || bus.digit_count !== 2'd1)
         begin n_bad++; $display("FAIL restore_fresh: got %h/%0d want 004/1", bus.edit_bcd, bus.digit_count); end
   endtask

   task automatic test_channel_wrap();
      apply_reset();
      tap(K5); tap(KOK);
      tap(KCH);
      n_cmp++; if (bus.channel !== 1'b1) begin n_bad++; $display("FAIL ch_to_1: got %0d want 1", bus.channel); end
      n_cmp++; if (bus.edit_bcd !== 12'h000 || bus.digit_count !== 2'd0 || bus.commit_bcd !== 12'h000)
         begin n_bad++; $display("FAIL ch1_load: got %h/%0d/%h want 000/0/000", bus.edit_bcd, bus.digit_count, bus.commit_bcd); end
      tap(K7); tap(KOK);
      n_cmp++; if (bus.commit_bcd !== 12'h007) begin n_bad++; $display("FAIL ch1_commit: got %h want 007", bus.commit_bcd); end
      tap(KCH);
      n_cmp++; if (bus.channel !== 1'b0) begin n_bad++; $display("FAIL ch_wrap: got %0d want 0", bus.channel); end
      n_cmp++; if (bus.edit_bcd !== 12'h005 || bus.digit_count !== 2'd1 || bus.commit_bcd !== 12'h005)
         begin n_bad++; $display("FAIL ch0_reload: got %h/%0d/%h want 005/1/005", bus.edit_bcd, bus.digit_count, bus.commit_bcd); end
   endtask

   task automatic test_toggles_page();
      int a, s, p;
      tap(KTA);
      n_cmp++; if (bus.toggle_a !== 1'b1 || bus.toggle_b !== 1'b0)
         begin n_bad++; $display("FAIL toggle_a_on: got %b%b want 10", bus.toggle_a, bus.toggle_b); end
      tap(KTB); tap(KTA);
      n_cmp++; if (bus.toggle_a !== 1'b0 || bus.toggle_b !== 1'b1)
         begin n_bad++; $display("FAIL toggle_b_on: got %b%b want 01", bus.toggle_a, bus.toggle_b); end
      press(KPG, 8, a, s, p);
      n_cmp++; if (p !== 1 || s !== 0) begin n_bad++; $display("FAIL next_page: got %0d page/%0d stb want 1/0", p, s); end
      n_cmp++; if (bus.edit_bcd !== 12'h005) begin n_bad++; $display("FAIL page_no_edit: got %h want 005", bus.edit_bcd); end
   endtask

   task automatic test_reset_mid_press();
      int a;
      a = 0;
      @(negedge clk);
      bus.key_pressed = 1'b1;
      bus.key_code    = K5;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         a += int'(bus.key_accept);
      end
      n_cmp++; if (a !== 0) begin n_bad++; $display("FAIL midpress_accept: got %0d want 0", a); end
      n_cmp++; if (bus.edit_bcd !== 12'h000 || bus.digit_count !== 2'd0 || bus.channel !== 1'b0 || bus.commit_bcd !== 12'h000)
         begin n_bad++; $display("FAIL midpress_state: got %h/%0d/%0d/%h want 000/0/0/000",
            bus.edit_bcd, bus.digit_count, bus.channel, bus.commit_bcd); end
      n_cmp++; if ({bus.toggle_a, bus.toggle_b, bus.commit_stb, bus.next_page} !== 4'b0)
         begin n_bad++; $display("FAIL midpress_flags: got %b want 0000",
            {bus.toggle_a, bus.toggle_b, bus.commit_stb, bus.next_page}); end
      @(negedge clk);
      bus.key_pressed = 1'b0;
      repeat (2) @(negedge clk);
      tap(K5);
      n_cmp++; if (bus.edit_bcd !== 12'h005) begin n_bad++; $display("FAIL repress_after_reset: got %h want 005", bus.edit_bcd); end
   endtask

   initial begin
      bus.tick        = 1'b1;
      bus.key_pressed = 1'b0;
      bus.key_code    = 4'd0;
      test_reset();
      test_debounce();
      test_entry_overflow();
      test_commit_restore();
      test_channel_wrap();
      test_toggles_page();
      test_reset_mid_press();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
